uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 217: clock cycles per UART bit; legal range 4..255; identical value to the paired transmitter.
REQ-002 SHALL have port i_Clock  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port i_Rst_L  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_RX_Serial  input  1  asynchronous serial line, idle high, 8N1 LSB-first.
REQ-005 SHALL have port o_RX_DV  output  1  one-cycle pulse: valid byte on o_RX_Byte.
REQ-006 SHALL have port o_RX_Byte  output  8  last correctly framed byte received.
REQ-007 SHALL have port o_RX_Error  output  1  one-cycle pulse: framing error (stop bit sampled low).
REQ-008 SHALL have port o_RX_Active  output  1  high from start-bit confirmation until frame end.

Function
REQ-009 SHALL pass i_RX_Serial through a two-flop synchronizer; all decisions use the second flop's output ("line").
REQ-010 SHALL implement states IDLE, RX_START_BIT, RX_DATA_BITS, RX_STOP_BIT, CLEANUP; any unused encoding -> IDLE.
REQ-011 IDLE: clock counter and bit index held at 0; line==0 -> RX_START_BIT.
REQ-012 RX_START_BIT: count up; at count==(CLKS_PER_BIT-1)/2 (integer division) sample line: 0 -> counter=0, o_RX_Active=1, RX_DATA_BITS; 1 -> glitch, IDLE, no output pulse.
REQ-013 RX_DATA_BITS: at count==CLKS_PER_BIT-1 sample line into shift register bit [index], counter=0; index 0..7, LSB first; after index 7 -> RX_STOP_BIT, index=0.
REQ-014 RX_STOP_BIT: at count==CLKS_PER_BIT-1 sample line: 1 -> o_RX_Byte<=shift register, o_RX_DV<=1; 0 -> o_RX_Error<=1, o_RX_Byte unchanged; both cases o_RX_Active<=0, -> CLEANUP.
REQ-015 CLEANUP: one cycle; o_RX_DV and o_RX_Error cleared; -> IDLE; hence each pulse is exactly one clock wide.
REQ-016 o_RX_DV and o_RX_Error SHALL never be high in the same cycle.
REQ-017 Counter SHALL be 8 bits; no wrap occurs within legal CLKS_PER_BIT range.
REQ-018 A new start edge SHALL be detectable immediately after CLEANUP (remaining half stop bit is high), so back-to-back frames with no idle gap are received.
REQ-019 Line low persisting after a framing error SHALL be treated as a new start bit (break condition yields repeated o_RX_Error pulses, no o_RX_DV).
REQ-020 o_RX_Byte SHALL hold its value between frames and across errors.

Reset
REQ-021 i_Rst_L low SHALL immediately force: state IDLE, counter 0, index 0, shift register 0x00, o_RX_Byte 0x00, o_RX_DV 0, o_RX_Error 0, o_RX_Active 0, synchronizer flops 1.
REQ-022 Reset mid-frame SHALL abandon the frame without any pulse; after release the block SHALL wait for a fresh falling edge.
REQ-023 Reset release SHALL be effective on the first rising i_Clock edge after i_Rst_L goes high.

Verification (CLKS_PER_BIT=8)
REQ-024 Frame 0xA5, ideal bit timing -> single one-cycle o_RX_DV, o_RX_Byte==0xA5, o_RX_Error never high, o_RX_DV within 76..80 clocks of start-bit falling edge.
REQ-025 Back-to-back 0x00 then 0xFF, zero idle gap -> two o_RX_DV pulses 80 clocks apart, bytes 0x00 then 0xFF.
REQ-026 Low glitch of 2 clocks on idle line -> no o_RX_DV/o_RX_Error, o_RX_Active stays 0, following frame 0x3C received correctly.
REQ-027 Frame 0x5A with stop bit driven 0 -> one o_RX_Error pulse, no o_RX_DV, o_RX_Byte retains previous value.
REQ-028 i_Rst_L asserted during data bit 4 of a frame -> all outputs 0 immediately, no pulse; next frame 0x81 received correctly.
REQ-029 Loopback from the team's uarttx (same CLKS_PER_BIT) over 256 bytes 0x00..0xFF -> every byte received in order, zero errors.

Source files
------------

// File: rtl/uart_rx_if.sv
// UART receiver signal bundle: serial line in, received byte and status out.
// Latency: none (wires only).
// Backpressure: none; the receiver pulses o_RX_DV / o_RX_Error for one cycle and never stalls.
//
// Signals:
//   i_RX_Serial  serial line into the receiver (idle high, 8N1, LSB first)
//   o_RX_DV      one-cycle pulse, o_RX_Byte holds a freshly framed byte
//   o_RX_Byte    last correctly framed byte
//   o_RX_Error   one-cycle pulse, stop bit was sampled low
//   o_RX_Active  high while a confirmed frame is being received
interface uart_rx_if;
    logic       i_RX_Serial;
    logic       o_RX_DV;
    logic [7:0] o_RX_Byte;
    logic       o_RX_Error;
    logic       o_RX_Active;

    // master: the receiver, which owns the byte stream
    modport master (
        input  i_RX_Serial,
        output o_RX_DV,
        output o_RX_Byte,
        output o_RX_Error,
        output o_RX_Active
    );

    // slave: whoever drives the line and consumes received bytes
    modport slave (
        output i_RX_Serial,
        input  o_RX_DV,
        input  o_RX_Byte,
        input  o_RX_Error,
        input  o_RX_Active
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with two-flop line synchronizer and mid-bit sampling.
// Latency: o_RX_DV about 9.5 bit times plus 3 clocks after the start-bit falling edge.
// Backpressure: none; results are one-cycle pulses and o_RX_Byte holds until the next good frame.
//
// Ports:
//   i_Clock  sole clock, rising edge
//   i_Rst_L  asynchronous active-low reset
//   rx       uart_rx_if.master (i_RX_Serial in; o_RX_DV, o_RX_Byte, o_RX_Error, o_RX_Active out)
module uart_rx #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic      i_Clock,
    input  logic      i_Rst_L,
    uart_rx_if.master rx
);

    localparam logic [2:0] IDLE         = 3'd0;
    localparam logic [2:0] RX_START_BIT = 3'd1;
    localparam logic [2:0] RX_DATA_BITS = 3'd2;
    localparam logic [2:0] RX_STOP_BIT  = 3'd3;
    localparam logic [2:0] CLEANUP      = 3'd4;

    // Start bit is re-checked at its midpoint; every later bit is sampled one
    // full bit period after the previous sample, i.e. also at mid-bit.
    localparam logic [7:0] HALF_BIT = 8'((CLKS_PER_BIT - 1) / 2);
    localparam logic [7:0] FULL_BIT = 8'(CLKS_PER_BIT - 1);

    logic       rx_meta;
    logic       rx_line;
    logic [2:0] state;
    logic [7:0] clk_count;
    logic [2:0] bit_index;
    logic [7:0] shift_reg;
    logic [7:0] rx_byte;
    logic       rx_dv;
    logic       rx_error;
    logic       rx_active;

    // Line resets high so a reset never looks like a start edge.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rx_meta <= 1'b1;
            rx_line <= 1'b1;
        end else begin
            rx_meta <= rx.i_RX_Serial;
            rx_line <= rx_meta;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state     <= IDLE;
            clk_count <= 8'd0;
            bit_index <= 3'd0;
            shift_reg <= 8'h00;
            rx_byte   <= 8'h00;
            rx_dv     <= 1'b0;
            rx_error  <= 1'b0;
            rx_active <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    clk_count <= 8'd0;
                    bit_index <= 3'd0;
                    if (!rx_line) begin
                        state <= RX_START_BIT;
                    end
                end

                RX_START_BIT: begin
                    if (clk_count == HALF_BIT) begin
                        if (!rx_line) begin
                            clk_count <= 8'd0;
                            rx_active <= 1'b1;
                            state     <= RX_DATA_BITS;
                        end else begin
                            // Low pulse shorter than half a bit: ignore silently.
                            state <= IDLE;
                        end
                    end else begin
                        clk_count <= clk_count + 8'd1;
                    end
                end

                RX_DATA_BITS: begin
                    if (clk_count == FULL_BIT) begin
                        clk_count            <= 8'd0;
                        shift_reg[bit_index] <= rx_line;
                        if (bit_index == 3'd7) begin
                            bit_index <= 3'd0;
                            state     <= RX_STOP_BIT;
                        end else begin
                            bit_index <= bit_index + 3'd1;
                        end
                    end else begin
                        clk_count <= clk_count + 8'd1;
                    end
                end

                RX_STOP_BIT: begin
                    if (clk_count == FULL_BIT) begin
                        clk_count <= 8'd0;
                        if (rx_line) begin
                            rx_byte <= shift_reg;
                            rx_dv   <= 1'b1;
                        end else begin
                            // Bad frame: keep the last good byte visible.
                            rx_error <= 1'b1;
                        end
                        rx_active <= 1'b0;
                        state     <= CLEANUP;
                    end else begin
                        clk_count <= clk_count + 8'd1;
                    end
                end

                CLEANUP: begin
                    // Leaves the second half of the stop bit for IDLE to watch,
                    // so a back-to-back start edge is not missed.
                    rx_dv    <= 1'b0;
                    rx_error <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign rx.o_RX_DV     = rx_dv;
    assign rx.o_RX_Byte   = rx_byte;
    assign rx.o_RX_Error  = rx_error;
    assign rx.o_RX_Active = rx_active;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 8 clocks per bit: directed frames, glitches, framing errors,
// mid-frame reset, break, random traffic and a 256-byte back-to-back sweep.
// The model records each frame's expected outcome and start cycle; one compare process checks every cycle.
module tb_uart_rx;

    localparam int CPB = 8;

    logic i_Clock;
    logic i_Rst_L;

    uart_rx_if rx_if ();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock (i_Clock),
        .i_Rst_L (i_Rst_L),
        .rx      (rx_if.master)
    );

    initial i_Clock = 1'b0;
    always #5 i_Clock = ~i_Clock;

    // Expected outcome of one frame: a good byte or a framing error, plus the
    // cycle at which the line fell. The pulse must land 76..80 cycles later.
    typedef struct {
        bit       is_err;
        logic [7:0] b;
        int       s;
    } ev_t;

    ev_t        ev_q[$];
    ev_t        ev_cur;
    int         cyc;
    int         n_cmp;
    int         n_bad;
    logic [7:0] model_byte;
    int         fs;
    bit         frame_real;
    int         dv_count;
    int         err_count;
    int         last_dv_cyc;
    int         prev_dv_cyc;
    bit         checking;

    always @(posedge i_Clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge i_Clock) begin
        if (i_Rst_L && checking) begin
            if (rx_if.o_RX_DV || rx_if.o_RX_Error) begin
                if (rx_if.o_RX_DV) begin
                    dv_count++;
                    prev_dv_cyc = last_dv_cyc;
                    last_dv_cyc = cyc;
                end
                if (rx_if.o_RX_Error) err_count++;
                check("dv_err_exclusive", 32'(rx_if.o_RX_DV & rx_if.o_RX_Error), 32'd0);
                check("pulse_expected", 32'(ev_q.size() > 0), 32'd1);
                if (ev_q.size() > 0) begin
                    ev_cur = ev_q.pop_front();
                    check("pulse_kind_is_error", 32'(rx_if.o_RX_Error), 32'(ev_cur.is_err));
                    check("pulse_latency_76_80", 32'(cyc - ev_cur.s), 32'(cyc - ev_cur.s >= 76 && cyc - ev_cur.s <= 80 ? cyc - ev_cur.s : 78));
                    if (!ev_cur.is_err) begin
                        check("dv_byte", 32'(rx_if.o_RX_Byte), 32'(ev_cur.b));
                        model_byte = ev_cur.b;
                    end
                end
            end
            check("byte_hold", 32'(rx_if.o_RX_Byte), 32'(model_byte));
            if (ev_q.size() > 0)
                check("pulse_by_deadline", 32'(cyc <= ev_q[0].s + 80), 32'd1);
            if (frame_real && cyc >= fs + 10 && cyc <= fs + 70)
                check("active_mid_frame", 32'(rx_if.o_RX_Active), 32'd1);
            else if (!frame_real || cyc > fs + 84)
                check("active_idle", 32'(rx_if.o_RX_Active), 32'd0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge i_Clock);
        #1;
    endtask

    task automatic idle(input int n);
        rx_if.i_RX_Serial = 1'b1;
        if (n > 0) tick(n);
    endtask

    // Drive one ideal 8N1 frame; stop_ok=0 drives the stop bit low.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        ev_t e;
        e.is_err = !stop_ok;
        e.b      = b;
        e.s      = cyc;
        ev_q.push_back(e);
        fs         = cyc;
        frame_real = 1'b1;
        rx_if.i_RX_Serial = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_if.i_RX_Serial = b[i];
            tick(CPB);
        end
        rx_if.i_RX_Serial = stop_ok;
        tick(CPB);
        rx_if.i_RX_Serial = 1'b1;
    endtask

    task automatic glitch(input int len);
        frame_real = 1'b0;
        rx_if.i_RX_Serial = 1'b0;
        tick(len);
        rx_if.i_RX_Serial = 1'b1;
    endtask

    // Line held low 160 cycles: the first error frame ends, the receiver
    // re-arms while the line is still low and reports a second error whose
    // effective start is 78 cycles after the first; the remaining low time
    // is too short to pass the next start-bit check.
    task automatic send_break();
        ev_t e;
        e.is_err = 1'b1;
        e.b      = 8'h00;
        e.s      = cyc;
        ev_q.push_back(e);
        fs         = cyc;
        frame_real = 1'b1;
        rx_if.i_RX_Serial = 1'b0;
        tick(78);
        e.s = cyc;
        ev_q.push_back(e);
        fs = cyc;
        tick(82);
        rx_if.i_RX_Serial = 1'b1;
    endtask

    int d0;
    int e0;
    int s_a5;
    logic [7:0] rb;
    int r;

    initial begin
        checking    = 1'b0;
        frame_real  = 1'b0;
        fs          = 0;
        model_byte  = 8'h00;
        i_Rst_L     = 1'b0;
        rx_if.i_RX_Serial = 1'b1;
        tick(3);

        check("reset_dv", 32'(rx_if.o_RX_DV), 32'd0);
        check("reset_err", 32'(rx_if.o_RX_Error), 32'd0);
        check("reset_byte", 32'(rx_if.o_RX_Byte), 32'h00);
        check("reset_active", 32'(rx_if.o_RX_Active), 32'd0);

        i_Rst_L = 1'b1;
        checking = 1'b1;
        tick(10);

        // Single frame 0xA5
        d0 = dv_count; e0 = err_count;
        s_a5 = cyc;
        send_frame(8'hA5, 1'b1);
        idle(100);
        check("a5_dv_count", 32'(dv_count - d0), 32'd1);
        check("a5_err_count", 32'(err_count - e0), 32'd0);
        check("a5_byte", 32'(rx_if.o_RX_Byte), 32'hA5);
        check("a5_latency_in_window", 32'(last_dv_cyc - s_a5 >= 76 && last_dv_cyc - s_a5 <= 80), 32'd1);

        // Back-to-back 0x00, 0xFF with no idle gap
        d0 = dv_count;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(100);
        check("b2b_dv_count", 32'(dv_count - d0), 32'd2);
        check("b2b_spacing", 32'(last_dv_cyc - prev_dv_cyc), 32'd80);
        check("b2b_last_byte", 32'(rx_if.o_RX_Byte), 32'hFF);

        // Two-clock glitch then 0x3C
        d0 = dv_count; e0 = err_count;
        glitch(2);
        idle(20);
        check("glitch_no_pulse", 32'(dv_count - d0 + err_count - e0), 32'd0);
        send_frame(8'h3C, 1'b1);
        idle(100);
        check("3c_dv_count", 32'(dv_count - d0), 32'd1);
        check("3c_byte", 32'(rx_if.o_RX_Byte), 32'h3C);

        // Framing error on 0x5A
        d0 = dv_count; e0 = err_count;
        send_frame(8'h5A, 1'b0);
        idle(100);
        check("5a_err_count", 32'(err_count - e0), 32'd1);
        check("5a_dv_count", 32'(dv_count - d0), 32'd0);
        check("5a_byte_kept", 32'(rx_if.o_RX_Byte), 32'h3C);

        // Reset during data bit 4 of 0xC3
        rb = 8'hC3;
        fs = cyc;
        frame_real = 1'b1;
        rx_if.i_RX_Serial = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rx_if.i_RX_Serial = rb[i];
            tick(CPB);
        end
        rx_if.i_RX_Serial = rb[4];
        tick(3);
        check("active_before_reset", 32'(rx_if.o_RX_Active), 32'd1);
        i_Rst_L    = 1'b0;
        frame_real = 1'b0;
        ev_q.delete();
        model_byte = 8'h00;
        #1;
        check("midreset_dv", 32'(rx_if.o_RX_DV), 32'd0);
        check("midreset_err", 32'(rx_if.o_RX_Error), 32'd0);
        check("midreset_byte", 32'(rx_if.o_RX_Byte), 32'h00);
        check("midreset_active", 32'(rx_if.o_RX_Active), 32'd0);
        rx_if.i_RX_Serial = 1'b1;
        tick(5);
        i_Rst_L = 1'b1;
        d0 = dv_count; e0 = err_count;
        idle(20);
        check("post_reset_quiet", 32'(dv_count - d0 + err_count - e0), 32'd0);
        send_frame(8'h81, 1'b1);
        idle(100);
        check("81_dv_count", 32'(dv_count - d0), 32'd1);
        check("81_byte", 32'(rx_if.o_RX_Byte), 32'h81);

        // Random traffic: good frames with short gaps, errors, glitches
        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                glitch(int'($urandom_range(1, 3)));
                idle(int'($urandom_range(8, 15)));
            end else if (r == 1) begin
                send_frame(8'($urandom), 1'b0);
                idle(int'($urandom_range(8, 20)));
            end else begin
                send_frame(8'($urandom), 1'b1);
                idle(int'($urandom_range(0, 6)));
            end
        end
        idle(100);

        // Every byte value back-to-back, in order
        d0 = dv_count; e0 = err_count;
        for (int i = 0; i < 256; i++) send_frame(8'(i), 1'b1);
        idle(100);
        check("sweep_dv_count", 32'(dv_count - d0), 32'd256);
        check("sweep_err_count", 32'(err_count - e0), 32'd0);
        check("sweep_last_byte", 32'(rx_if.o_RX_Byte), 32'hFF);

        // Break condition
        d0 = dv_count; e0 = err_count;
        send_break();
        idle(100);
        check("break_err_count", 32'(err_count - e0), 32'd2);
        check("break_dv_count", 32'(dv_count - d0), 32'd0);
        check("break_byte_kept", 32'(rx_if.o_RX_Byte), 32'hFF);

        check("queue_drained", 32'(ev_q.size()), 32'd0);
        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
